// File: rtl/uart_result_streamer_pkg.sv
// Shared types for the result-frame streamer.
// Byte selector, FSM encodings and frame constants.
package uart_result_streamer_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FETCH,
    ST_LATCH
  } fsm_t;

  typedef enum logic [1:0] {
    IS_IDLE,
    IS_ISSUE,
    IS_ACK,
    IS_DRAIN
  } iss_t;

  typedef enum logic [2:0] {
    SEL_SOF,
    SEL_CNT,
    SEL_HI,
    SEL_LO,
    SEL_CSUM
  } sel_t;

  function automatic logic in_csum(sel_t s);
    return (s == SEL_CNT) || (s == SEL_HI) ||
           (s == SEL_LO);
  endfunction

endpackage

// File: rtl/uart_result_streamer_tx_byte_issuer.sv
// One-byte handshake against a uart_tx busy flag.
// Accepts a byte, pulses start, waits busy high then low.
import uart_result_streamer_pkg::*;

module tx_byte_issuer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] req_byte,
  output logic       ack_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  iss_t st;
  iss_t st_nxt;
  logic take;

  // state and held byte; a request may chain off a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IS_IDLE;
      tx_data <= 8'h00;
    end else begin
      st <= st_nxt;
      if (take) tx_data <= req_byte;
    end
  end

  // issue / ack / drain sequencing
  always_comb begin
    st_nxt   = st;
    take     = 1'b0;
    tx_start = 1'b0;
    ack_done = 1'b0;
    unique case (st)
      IS_IDLE: begin
        if (req) begin
          take   = 1'b1;
          st_nxt = IS_ISSUE;
        end
      end
      IS_ISSUE: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          st_nxt   = IS_ACK;
        end
      end
      IS_ACK: begin
        if (tx_busy) st_nxt = IS_DRAIN;
      end
      IS_DRAIN: begin
        if (!tx_busy) begin
          ack_done = 1'b1;
          take     = req;
          st_nxt   = req ? IS_ISSUE : IS_IDLE;
        end
      end
      default: st_nxt = IS_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_result_streamer.sv
// Streams a result matrix as one framed UART packet:
// SOF, count, elements MSB first, XOR checksum.
import uart_result_streamer_pkg::*;

module uart_result_streamer #(
  parameter int N_ELEMS = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              active,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(N_ELEMS - 1);
  localparam logic [7:0] CNT_BYTE = 8'(N_ELEMS);

  fsm_t              st;
  fsm_t              st_nxt;
  sel_t              sel;
  sel_t              sel_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [7:0]        csum;
  logic [7:0]        lo_hold;
  logic              req;
  logic [7:0]        req_byte;
  logic              ack_done;

  assign active  = (st != ST_IDLE);
  assign rd_addr = idx;

  tx_byte_issuer u_issuer (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_byte (req_byte),
    .ack_done (ack_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  // frame state, element index, low byte and checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      sel     <= SEL_SOF;
      idx     <= '0;
      csum    <= 8'h00;
      lo_hold <= 8'h00;
    end else begin
      st  <= st_nxt;
      sel <= sel_nxt;
      idx <= idx_nxt;
      if (st == ST_LATCH) lo_hold <= rd_data[7:0];
      if (st == ST_IDLE && go)
        csum <= 8'h00;
      else if (req && in_csum(sel_nxt))
        csum <= csum ^ req_byte;
    end
  end

  // byte sequencing; req always names the byte in sel_nxt
  always_comb begin
    st_nxt   = st;
    sel_nxt  = sel;
    idx_nxt  = idx;
    req      = 1'b0;
    req_byte = 8'h00;
    rd_en    = 1'b0;
    done     = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (go) begin
          st_nxt   = ST_SEND;
          sel_nxt  = SEL_SOF;
          req      = 1'b1;
          req_byte = SOF_BYTE;
        end
      end
      ST_SEND: begin
        if (ack_done) begin
          unique case (sel)
            SEL_SOF: begin
              sel_nxt  = SEL_CNT;
              req      = 1'b1;
              req_byte = CNT_BYTE;
            end
            SEL_CNT: begin
              sel_nxt = SEL_HI;
              st_nxt  = ST_FETCH;
            end
            SEL_HI: begin
              sel_nxt  = SEL_LO;
              req      = 1'b1;
              req_byte = lo_hold;
            end
            SEL_LO: begin
              if (idx == LAST_IDX) begin
                sel_nxt  = SEL_CSUM;
                idx_nxt  = '0;
                req      = 1'b1;
                req_byte = csum;
              end else begin
                sel_nxt = SEL_HI;
                idx_nxt = idx + ADDR_W'(1);
                st_nxt  = ST_FETCH;
              end
            end
            SEL_CSUM: begin
              done    = 1'b1;
              sel_nxt = SEL_SOF;
              st_nxt  = ST_IDLE;
            end
            default: begin
              sel_nxt = SEL_SOF;
              st_nxt  = ST_IDLE;
            end
          endcase
        end
      end
      ST_FETCH: begin
        rd_en  = 1'b1;
        st_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        req      = 1'b1;
        req_byte = rd_data[15:8];
        st_nxt   = ST_SEND;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_result_streamer.sv
// Directed bench for uart_result_streamer.
// Small (N=2) and full (N=255) instances with a uart_tx busy model.
module tb_uart_result_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int d0;

  logic        go_s, active_s, done_s, rd_en_s;
  logic        tx_start_s, tx_busy_s, force_s;
  logic [0:0]  rd_addr_s;
  logic [15:0] rd_data_s;
  logic [7:0]  tx_data_s;
  int          bcnt_s = 0;
  int          done_n_s = 0;
  int          done_cyc_s = 0;
  logic [15:0] ram_s [0:1];
  logic [7:0]  bytes_s [$];
  int          tcyc_s [$];
  logic [0:0]  addr_s [$];

  logic        go_b, active_b, done_b, rd_en_b;
  logic        tx_start_b, tx_busy_b;
  logic [7:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic [7:0]  tx_data_b;
  int          bcnt_b = 0;
  int          done_n_b = 0;
  int          done_cyc_b = 0;
  logic [7:0]  bytes_b [$];
  int          tcyc_b [$];
  logic [7:0]  addr_b [$];

  logic [7:0]  exp_s [7];
  int          gap_s [6];
  logic [7:0]  cs;
  logic [15:0] e;

  uart_result_streamer #(.N_ELEMS(2), .ADDR_W(1)) u_small (
    .clk(clk), .rst(rst), .go(go_s),
    .active(active_s), .done(done_s),
    .rd_en(rd_en_s), .rd_addr(rd_addr_s),
    .rd_data(rd_data_s), .tx_start(tx_start_s),
    .tx_data(tx_data_s), .tx_busy(tx_busy_s)
  );

  uart_result_streamer #(.N_ELEMS(255), .ADDR_W(8)) u_big (
    .clk(clk), .rst(rst), .go(go_b),
    .active(active_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .tx_start(tx_start_b),
    .tx_data(tx_data_b), .tx_busy(tx_busy_b)
  );

  function automatic logic [15:0] belem(input logic [7:0] a);
    return {a, a + 8'h11};
  endfunction

  assign tx_busy_s = (bcnt_s != 0) || force_s;
  assign tx_busy_b = (bcnt_b != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) bcnt_s <= 0;
    else if (tx_start_s) bcnt_s <= 10;
    else if (bcnt_s != 0) bcnt_s <= bcnt_s - 1;
    if (rst) bcnt_b <= 0;
    else if (tx_start_b) bcnt_b <= 10;
    else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    if (rd_en_s) rd_data_s <= ram_s[rd_addr_s];
    if (rd_en_b) rd_data_b <= belem(rd_addr_b);
    if (tx_start_s) begin
      bytes_s.push_back(tx_data_s);
      tcyc_s.push_back(cyc);
    end
    if (tx_start_b) begin
      bytes_b.push_back(tx_data_b);
      tcyc_b.push_back(cyc);
    end
    if (rd_en_s) addr_s.push_back(rd_addr_s);
    if (rd_en_b) addr_b.push_back(rd_addr_b);
    if (done_s) begin
      done_n_s   <= done_n_s + 1;
      done_cyc_s <= cyc;
    end
    if (done_b) begin
      done_n_b   <= done_n_b + 1;
      done_cyc_b <= cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_s();
    bytes_s.delete();
    tcyc_s.delete();
    addr_s.delete();
  endtask

  task automatic wait_done_s(input int max);
    int s0 = done_n_s;
    int n = 0;
    while (done_n_s == s0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_s_seen", 32'(done_n_s - s0), 32'd1);
  endtask

  task automatic wait_done_b(input int max);
    int s0 = done_n_b;
    int n = 0;
    while (done_n_b == s0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_b_seen", 32'(done_n_b - s0), 32'd1);
  endtask

  initial begin
    ram_s[0]  = 16'h1234;
    ram_s[1]  = 16'hABCD;
    rd_data_s = 16'h0000;
    rd_data_b = 16'h0000;
    exp_s = '{8'hA5, 8'h02, 8'h12, 8'h34,
              8'hAB, 8'hCD, 8'h42};
    gap_s = '{12, 14, 12, 14, 12, 12};
    force_s = 1'b0;
    rst  = 1'b1;
    go_s = 1'b1;
    go_b = 1'b1;

    // reset held 3 cycles with go asserted
    repeat (3) @(negedge clk);
    chk("rst_active", 32'(active_s), 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk("rst_rd_en", 32'(rd_en_s), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_s), 32'd0);
    chk("rst_tx_start", 32'(tx_start_s), 32'd0);
    chk("rst_tx_data", 32'(tx_data_s), 32'd0);
    chk("rst_b_active", 32'(active_b), 32'd0);
    chk("rst_b_tx_data", 32'(tx_data_b), 32'd0);
    rst  = 1'b0;
    go_s = 1'b0;
    go_b = 1'b0;
    @(negedge clk);
    chk("go_in_rst", 32'(active_s), 32'd0);

    // basic frame
    clr_s();
    go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
    chk("c1_active", 32'(active_s), 32'd1);
    chk("c1_tx_start", 32'(tx_start_s), 32'd1);
    chk("c1_tx_data", 32'(tx_data_s), 32'hA5);
    wait_done_s(400);
    chk("basic_nbytes", 32'(bytes_s.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("basic_byte%0d", i),
          32'(bytes_s[i]), 32'(exp_s[i]));
    for (int i = 0; i < 6; i++)
      chk($sformatf("basic_gap%0d", i),
          32'(tcyc_s[i+1] - tcyc_s[i]), 32'(gap_s[i]));
    chk("basic_done_gap",
        32'(done_cyc_s - tcyc_s[6]), 32'd11);
    chk("basic_active_off", 32'(active_s), 32'd0);
    chk("basic_rd_cnt", 32'(addr_s.size()), 32'd2);
    chk("basic_rd_a0", 32'(addr_s[0]), 32'd0);
    chk("basic_rd_a1", 32'(addr_s[1]), 32'd1);

    // reset during third byte drain
    clr_s();
    d0 = done_n_s;
    go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
    for (int n = 0; n < 100 && bytes_s.size() < 3; n++)
      @(negedge clk);
    chk("mid_reach3", 32'(bytes_s.size()), 32'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_tx_start", 32'(tx_start_s), 32'd0);
    chk("mid_active", 32'(active_s), 32'd0);
    chk("mid_busy", 32'(tx_busy_s), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done", 32'(done_n_s - d0), 32'd0);
    clr_s();
    go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
    wait_done_s(400);
    chk("mid_nbytes", 32'(bytes_s.size()), 32'd7);
    chk("mid_sof", 32'(bytes_s[0]), 32'hA5);
    chk("mid_csum", 32'(bytes_s[6]), 32'h42);

    // go every 5 cycles through one frame
    clr_s();
    d0 = done_n_s;
    for (int c = 0; c < 300 && done_n_s == d0; c++) begin
      go_s = (c % 5 == 0);
      @(negedge clk);
    end
    go_s = 1'b0;
    repeat (30) @(negedge clk);
    chk("spam_done", 32'(done_n_s - d0), 32'd1);
    chk("spam_nbytes", 32'(bytes_s.size()), 32'd7);
    chk("spam_rd_cnt", 32'(addr_s.size()), 32'd2);
    chk("spam_active", 32'(active_s), 32'd0);

    // busy hold-off: 20 cycles of forced busy around go
    clr_s();
    force_s = 1'b1;
    repeat (10) @(negedge clk);
    go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
    chk("hold_active", 32'(active_s), 32'd1);
    chk("hold_start0", 32'(tx_start_s), 32'd0);
    repeat (9) @(negedge clk);
    chk("hold_start1", 32'(tx_start_s), 32'd0);
    force_s = 1'b0;
    #1;
    chk("hold_release", 32'(tx_start_s), 32'd1);
    chk("hold_sof", 32'(tx_data_s), 32'hA5);
    @(negedge clk);
    wait_done_s(400);
    chk("hold_nbytes", 32'(bytes_s.size()), 32'd7);
    chk("hold_csum", 32'(bytes_s[6]), 32'h42);

    // full-size frame
    cs = 8'hFF;
    for (int i = 0; i < 255; i++) begin
      e  = belem(8'(i));
      cs = cs ^ e[15:8] ^ e[7:0];
    end
    go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    wait_done_b(8000);
    e = belem(8'd254);
    chk("big_nbytes", 32'(bytes_b.size()), 32'd513);
    chk("big_sof", 32'(bytes_b[0]), 32'hA5);
    chk("big_cnt", 32'(bytes_b[1]), 32'hFF);
    chk("big_hi0", 32'(bytes_b[2]), 32'h00);
    chk("big_lo0", 32'(bytes_b[3]), 32'h11);
    chk("big_lo254", 32'(bytes_b[511]), 32'(e[7:0]));
    chk("big_csum", 32'(bytes_b[512]), 32'(cs));
    chk("big_len", 32'(done_cyc_b - tcyc_b[0]), 32'd6665);
    chk("big_rd_cnt", 32'(addr_b.size()), 32'd255);
    chk("big_rd_last", 32'(addr_b[254]), 32'd254);
    chk("big_idx_wrap", 32'(rd_addr_b), 32'd0);
    chk("big_active", 32'(active_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_result_streamer.md
# uart_result_streamer

Frame sequencer that owns the `uart_tx` byte transmitter and streams a completed result matrix to the host. On a `go` pulse it reads `N_ELEMS` 16-bit elements from the result RAM and sends one fixed frame:

- SOF byte `0xA5`
- element-count byte
- each element, MSB byte first
- XOR checksum byte

It sits between the multiplier's result buffer and `uart_tx`, and is that transmitter's only driver.

## Interface
- `N_ELEMS`, default 16: elements per frame; legal range 1..255.
- `ADDR_W`, default 4: result-RAM address width; must satisfy 2^ADDR_W ≥ N_ELEMS.
- `clk` in 1: single clock, shared with `uart_tx`.
- `rst` in 1: reset, synchronous, active-high.
- `go` in 1: start a frame; sampled only in IDLE; ignored while `active`=1.
- `active` out 1: high from the cycle after an accepted `go` until `done`.
- `done` out 1: one-cycle pulse when the frame is complete.
- `rd_en` out 1: result-RAM read strobe.
- `rd_addr` out ADDR_W: result-RAM address.
- `rd_data` in 16: RAM read data, valid exactly 1 cycle after `rd_en`.
- `tx_start` out 1: to `uart_tx.start`; single-cycle pulse.
- `tx_data` out 8: to `uart_tx.data`; valid while `tx_start`=1, held otherwise.
- `tx_busy` in 1: from `uart_tx.busy`.

## Operation
- **Reset values:** all outputs are 0, including `tx_data`=0x00. Internal state: FSM=IDLE, `idx`=0, `csum`=0, byte selector=SOF.
- **States:**
  - IDLE
  - ISSUE: assert `tx_start` for 1 cycle, but only if `tx_busy`=0; otherwise hold in ISSUE with `tx_start`=0.
  - ACK: wait for `tx_busy`=1.
  - DRAIN: wait for `tx_busy`=0.
  - FETCH: `rd_en`=1, `rd_addr`=`idx`.
  - LATCH: capture `rd_data` into a 16-bit holding register.
- **Byte order:** SOF, CNT, {HI, LO} × N_ELEMS, CSUM.
  - CNT = N_ELEMS[7:0].
  - HI = element[15:8]; LO = element[7:0].
  - CSUM = XOR of CNT and every element byte. SOF is excluded.
- **Transitions:**
  - IDLE + `go` → ISSUE(SOF).
  - DRAIN done → next byte. If the next byte is HI, go to FETCH → LATCH → ISSUE; otherwise go directly to ISSUE.
  - After the LO byte: `idx` increments. If `idx` = N_ELEMS−1 before the increment, next byte is CSUM.
  - CSUM DRAIN done → IDLE, with `done`=1 for that one cycle and `active`→0.
- **Checksum register:** cleared on an accepted `go`, updated on each ISSUE of CNT/HI/LO.
- **Counter wrap:** `idx` never exceeds N_ELEMS−1 and is reset to 0 at frame end.
- **`go` during frame:** a `go` while `active` is dropped, not queued.
- **`go` coincident with `done`:** the FSM is still leaving DRAIN, so this `go` is ignored. The next `go` must arrive in IDLE.
- **Reset mid-frame:** `rst` returns everything to reset values within 1 cycle. `tx_start` is 0 on the cycle after `rst`. `uart_tx` shares `rst`, so the line returns idle-high. No partial frame resumes.

## Timing
- Accepted `go` in cycle 0 → `active`=1 and `tx_start`=1 with `tx_data`=0xA5 in cycle 1.
- `uart_tx` raises `busy` 1 cycle after sampling `start` and holds it for 10 cycles.
- ACK exits after 1 cycle; DRAIN exits the first cycle `tx_busy`=0.
- **Issue spacing** (between consecutive `tx_start` pulses):
  - 12 cycles for SOF→CNT, HI→LO, LO→CSUM.
  - 14 cycles into a HI byte (FETCH + LATCH).
- `done` asserts 11 cycles after the CSUM `tx_start`.
- **Total frame**, from `tx_start`(SOF) to `done`: 12·(2N+2) + 2N + 11 cycles.
- `rd_en` is high for exactly 1 cycle per element; `rd_addr` is stable during it.

## Structure
- **Shared package:**
  - SOF constant `8'hA5`.
  - FSM state encoding.
  - Byte-selector encoding (SOF/CNT/HI/LO/CSUM).
- **Sub-module `tx_byte_issuer`:** implements ISSUE/ACK/DRAIN against `tx_busy`. Interface: `req`, `byte`, `ack_done`. It is reusable by any future UART client.
- The top-level FSM owns only frame sequencing, the RAM read, and the checksum.
- `uart_tx` is instantiated outside this block.

## Test plan
- **Basic frame:** N_ELEMS=2, RAM={0x1234, 0xABCD}, pulse `go` → serial bytes A5 02 12 34 AB CD 42. Then one `done` pulse, `active` low, exactly 2 `rd_en` pulses at addresses 0 and 1.
- **Reset:** hold `rst` 3 cycles → all outputs 0. A `go` during `rst` has no effect.
- **Mid-frame reset:** assert `rst` during the 3rd byte's DRAIN → `tx_start`=0 and `active`=0 the next cycle. A fresh `go` then yields a complete frame starting with A5.
- **`go` spam:** pulse `go` every 5 cycles through a frame → exactly one frame, one `done`.
- **Busy hold-off:** force `tx_busy`=1 for 20 cycles before `go` → `tx_start` stays 0 until `tx_busy` falls, then SOF is issued the next cycle.
- **Full size and timing:** N_ELEMS=255 with an incrementing pattern → CNT=0xFF, `idx` wraps back to 0, checksum matches the model, frame length = 12·512 + 521 cycles.
